rom_arbiter: RTL and testbench

//  Shares the single combinational program ROM (8-bit addr -> 8-bit data) between two

---
 rtl/rom_arb_pkg.sv | 20 ++
 rtl/rom_arbiter_rr_arb2.sv | 50 +++++
 rtl/rom_arbiter.sv | 117 +++++++++++
 tb/tb_rom_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-requester program-ROM burst arbiter.
// Optional build macro used by this slice: ROM_ARB_FIXED_PRIO_EN.
package rom_arb_pkg;

    localparam int unsigned ROM_AW = 8;
    localparam int unsigned ROM_DW = 8;
    localparam int unsigned ROM_LW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // A zero length field means the maximum burst of 2**lw beats.
    function automatic int unsigned len_to_beats(input int unsigned len, input int unsigned lw);
        return (len == 0) ? (32'd1 << lw) : len;
    endfunction

endpackage

// File: rtl/rom_arbiter_rr_arb2.sv
// Two-way grant logic for the ROM arbiter: round-robin by default, fixed priority
// (requester 0 wins) when ROM_ARB_FIXED_PRIO_EN is defined.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

`ifdef ROM_ARB_FIXED_PRIO_EN
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ rst;

    always_comb begin
        o_gnt = '0;
        if (i_en) begin
            o_gnt[0] = i_req[0];
            o_gnt[1] = i_req[1] & ~i_req[0];
        end
    end
`else
    // r_ptr names the favoured requester; a grant is always a handshake.
    logic r_ptr;

    always_comb begin
        o_gnt = '0;
        if (i_en) begin
            if (!r_ptr) begin
                o_gnt[0] = i_req[0];
                o_gnt[1] = i_req[1] & ~i_req[0];
            end else begin
                o_gnt[1] = i_req[1];
                o_gnt[0] = i_req[0] & ~i_req[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (o_gnt[0]) begin
            r_ptr <= 1'b1;
        end else if (o_gnt[1]) begin
            r_ptr <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/rom_arbiter.sv
// Burst-read arbiter sharing one combinational program ROM between two requesters.
// Build macro ROM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned AW = ROM_AW,
    parameter int unsigned DW = ROM_DW,
    parameter int unsigned LW = ROM_LW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [AW-1:0] req0_addr,
    input  logic [LW-1:0] req0_len,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [AW-1:0] req1_addr,
    input  logic [LW-1:0] req1_len,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_id,
    output logic          rsp_last,
    output logic          busy
);

    localparam int unsigned RW = LW + 1;

    state_t        r_state;
    logic [AW-1:0] r_rom_addr;
    logic [RW-1:0] r_remaining;
    logic [DW-1:0] r_rsp_data;
    logic          r_rsp_valid;
    logic          r_rsp_id;
    logic          r_rsp_last;

    logic          w_en;
    logic [1:0]    w_gnt;
    logic [AW-1:0] w_sel_addr;
    logic [LW-1:0] w_sel_len;
    logic [RW-1:0] w_beats;
    logic          w_issue;

    assign w_en = (r_state == IDLE) && !rst;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_en),
        .i_req ({req1_valid, req0_valid}),
        .o_gnt (w_gnt)
    );

    assign req0_ready = w_gnt[0];
    assign req1_ready = w_gnt[1];

    assign w_sel_addr = w_gnt[1] ? req1_addr : req0_addr;
    assign w_sel_len  = w_gnt[1] ? req1_len  : req0_len;
    assign w_beats    = RW'(len_to_beats(32'(w_sel_len), LW));

    // A new beat may be loaded when the output register is empty or being drained.
    assign w_issue = !r_rsp_valid || rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rom_addr  <= '0;
            r_remaining <= '0;
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_last  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_gnt) begin
                        r_rom_addr  <= w_sel_addr;
                        r_remaining <= w_beats;
                        r_rsp_id    <= w_gnt[1];
                        r_state     <= BURST;
                    end
                end
                BURST: begin
                    if (w_issue) begin
                        r_rsp_data  <= rom_data;
                        r_rsp_valid <= 1'b1;
                        r_rsp_last  <= (r_remaining == RW'(1));
                        r_rom_addr  <= r_rom_addr + AW'(1);
                        r_remaining <= r_remaining - RW'(1);
                        if (r_remaining == RW'(1)) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_last  <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rom_addr  = r_rom_addr;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign rsp_last  = r_rsp_last;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a small ROM model driven from rom_addr.
module tb_rom_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0;
    logic       req0_ready;
    logic [7:0] req0_addr = '0;
    logic [3:0] req0_len = '0;
    logic       req1_valid = 1'b0;
    logic       req1_ready;
    logic [7:0] req1_addr = '0;
    logic [3:0] req1_len = '0;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_data;
    logic       rsp_id;
    logic       rsp_last;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

`ifdef ROM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    rom_arbiter #(.AW(8), .DW(8), .LW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_len   (req0_len),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_len   (req1_len),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .rsp_last   (rsp_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_lut(input logic [7:0] a);
        case (a)
            8'h00: return 8'hAA;
            8'h01: return 8'hFF;
            8'h02: return 8'hF4;
            8'h03: return 8'hB2;
            8'h04: return 8'hE0;
            8'h05: return 8'hD3;
            8'h06: return 8'hF1;
            8'h07: return 8'hB6;
            8'h08: return 8'hA3;
            default: return 8'h00;
        endcase
    endfunction

    always_comb rom_data = rom_lut(rom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic         id;
        logic [7:0]   addr;
        logic [3:0]   len;
        int           nbeats;
        logic [127:0] exp;   // byte k of the burst in bits [8k+7:8k]
    } vec_t;

    vec_t vecs[5];

    // Starts at a negedge with the arbiter idle; ends at the negedge after the burst drains.
    task automatic run_burst(input vec_t v, input int idx);
        if (v.id) begin
            req1_valid = 1'b1; req1_addr = v.addr; req1_len = v.len;
        end else begin
            req0_valid = 1'b1; req0_addr = v.addr; req0_len = v.len;
        end
        #1;
        chk($sformatf("v%0d_ready_granted", idx), v.id ? req1_ready : req0_ready, 1);
        chk($sformatf("v%0d_ready_other", idx), v.id ? req0_ready : req1_ready, 0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk($sformatf("v%0d_busy", idx), busy, 1);
        chk($sformatf("v%0d_no_early_rsp", idx), rsp_valid, 0);
        chk($sformatf("v%0d_rom_addr", idx), rom_addr, v.addr);
        for (int k = 0; k < v.nbeats; k++) begin
            @(negedge clk);
            chk($sformatf("v%0d_b%0d_valid", idx, k), rsp_valid, 1);
            chk($sformatf("v%0d_b%0d_data", idx, k), rsp_data, v.exp[k*8 +: 8]);
            chk($sformatf("v%0d_b%0d_id", idx, k), rsp_id, v.id);
            chk($sformatf("v%0d_b%0d_last", idx, k), rsp_last, (k == v.nbeats - 1));
        end
        @(negedge clk);
        chk($sformatf("v%0d_end_valid", idx), rsp_valid, 0);
        chk($sformatf("v%0d_end_busy", idx), busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic       st_rdy[6];
        logic       st_val[7];
        logic [7:0] st_dat[7];
        logic       st_lst[7];
        logic [7:0] win_data;

        vecs[0] = '{id: 1'b0, addr: 8'h00, len: 4'd4, nbeats: 4,
                    exp: {8'hB2, 8'hF4, 8'hFF, 8'hAA}};
        vecs[1] = '{id: 1'b1, addr: 8'hFE, len: 4'd3, nbeats: 3,
                    exp: {8'hAA, 8'h00, 8'h00}};
        vecs[2] = '{id: 1'b0, addr: 8'h00, len: 4'd0, nbeats: 16,
                    exp: {56'h0, 8'hA3, 8'hB6, 8'hF1, 8'hD3, 8'hE0, 8'hB2, 8'hF4, 8'hFF, 8'hAA}};
        vecs[3] = '{id: 1'b0, addr: 8'hFF, len: 4'd1, nbeats: 1, exp: {8'h00}};
        vecs[4] = '{id: 1'b1, addr: 8'h07, len: 4'd2, nbeats: 2, exp: {8'hA3, 8'hB6}};

        // Reset state, with a request pending that must not be acknowledged.
        req0_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_last", rsp_last, 0);
        chk("rst_busy", busy, 0);
        req0_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_burst(vecs[i], i);

        // Contention: req0 re-requests immediately while req1 keeps waiting.
        req0_valid = 1'b1; req0_addr = 8'h05; req0_len = 4'd1;
        req1_valid = 1'b1; req1_addr = 8'h06; req1_len = 4'd1;
        #1;
        chk("arb1_req0_ready", req0_ready, 1);
        chk("arb1_req1_ready", req1_ready, 0);
        @(negedge clk);
        chk("arb1_busy_ready0", req0_ready, 0);
        chk("arb1_busy_ready1", req1_ready, 0);
        @(negedge clk);
        chk("arb1_data", rsp_data, 8'hD3);
        chk("arb1_id", rsp_id, 0);
        chk("arb1_last", rsp_last, 1);
        @(negedge clk);
        chk("arb2_idle_valid", rsp_valid, 0);
        chk("arb2_req0_ready", req0_ready, FIXED);
        chk("arb2_req1_ready", req1_ready, !FIXED);
        @(negedge clk);
        if (FIXED) req0_valid = 1'b0; else req1_valid = 1'b0;
        win_data = FIXED ? 8'hD3 : 8'hF1;
        @(negedge clk);
        chk("arb2_data", rsp_data, win_data);
        chk("arb2_id", rsp_id, !FIXED);
        @(negedge clk);
        chk("arb3_req0_ready", req0_ready, !FIXED);
        chk("arb3_req1_ready", req1_ready, FIXED);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        win_data = FIXED ? 8'hF1 : 8'hD3;
        @(negedge clk);
        chk("arb3_data", rsp_data, win_data);
        chk("arb3_id", rsp_id, FIXED);
        @(negedge clk);
        chk("arb3_end_busy", busy, 0);

        // Backpressure, including a stall on the final beat.
        st_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        st_val = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        st_dat = '{8'hF4, 8'hB2, 8'hB2, 8'hB2, 8'hE0, 8'hE0, 8'h00};
        st_lst = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        req0_valid = 1'b1; req0_addr = 8'h02; req0_len = 4'd3;
        rsp_ready = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_valid", j), rsp_valid, st_val[j]);
            if (st_val[j]) chk($sformatf("stall%0d_data", j), rsp_data, st_dat[j]);
            chk($sformatf("stall%0d_last", j), rsp_last, st_lst[j]);
            if (j < 6) rsp_ready = st_rdy[j];
        end
        rsp_ready = 1'b1;
        chk("stall_end_busy", busy, 0);

        // Reset in the middle of a burst.
        @(negedge clk);
        req0_valid = 1'b1; req0_addr = 8'h00; req0_len = 4'd4;
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_beat1_data", rsp_data, 8'hFF);
        rst = 1'b1;
        req0_valid = 1'b1; req0_addr = 8'h03; req0_len = 4'd2;
        req1_valid = 1'b1; req1_addr = 8'h03; req1_len = 4'd2;
        #1;
        chk("mid_rst_ready0", req0_ready, 0);
        chk("mid_rst_ready1", req1_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rom_addr", rom_addr, 0);
        chk("mid_rst_last", rsp_last, 0);
        chk("mid_rst_data", rsp_data, 0);
        #1;
        chk("mid_rst_ptr_ready0", req0_ready, 1);
        chk("mid_rst_ptr_ready1", req1_ready, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        run_burst('{id: 1'b1, addr: 8'h03, len: 4'd2, nbeats: 2, exp: {8'hE0, 8'hB2}}, 5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
